// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - two-digit BCD seconds counter with tick prescaler
//
// Purpose: counts a units/tens BCD pair up or down once every TICK_DIV
// enabled clock cycles, with parallel digit loads and wrap between 00 and
// TENS_MAX9.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   reset        synchronous active-high clear of all state
//   enable       run/stop; prescaler and counting advance only while high
//   up           count direction, 1 = up, 0 = down (sampled on step edges)
//   load0        load units digit from load0_value (clamped to 9)
//   load0_value  new units digit
//   load1        load tens digit from load1_value (clamped to TENS_MAX)
//   load1_value  new tens digit
//   q0           units digit, 0-9
//   q1           tens digit, 0-TENS_MAX
//   tick         one-cycle pulse marking a count step
//   wrap         one-cycle pulse marking rollover/underflow
module stopwatch_counter #(
  parameter int TICK_DIV = 50_000_000,
  parameter int TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       up,
  input  logic       load0,
  input  logic [3:0] load0_value,
  input  logic       load1,
  input  logic [3:0] load1_value,
  output logic [3:0] q0,
  output logic [3:0] q1,
  output logic       tick,
  output logic       wrap
);

  localparam int             CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [3:0]     TMAX     = 4'(TENS_MAX);

  logic [CW-1:0] cnt;
  logic          step_req;
  logic          any_load;
  logic [3:0]    ld0;
  logic [3:0]    ld1;
  logic [3:0]    nq0_up;
  logic [3:0]    nq1_up;
  logic          wrap_up;
  logic [3:0]    nq0_dn;
  logic [3:0]    nq1_dn;
  logic          wrap_dn;

  always_comb begin
    step_req = enable && (cnt == CNT_LAST);
    any_load = load0 || load1;
    ld0      = (load0_value > 4'd9) ? 4'd9 : load0_value;
    ld1      = (load1_value > TMAX) ? TMAX : load1_value;

    // Count-up candidate values.
    nq0_up  = q0;
    nq1_up  = q1;
    wrap_up = 1'b0;
    if (q0 > 4'd9) begin
      // Corrupt units digit is recovered to 0 without propagating a carry.
      nq0_up = 4'd0;
    end else if (q0 < 4'd9) begin
      nq0_up = q0 + 4'd1;
    end else begin
      nq0_up = 4'd0;
      if (q1 == TMAX) begin
        nq1_up  = 4'd0;
        wrap_up = 1'b1;
      end else begin
        nq1_up = q1 + 4'd1;
      end
    end
    if (q1 > TMAX) begin
      nq1_up  = 4'd0;
      wrap_up = 1'b0;
    end

    // Count-down candidate values.
    nq0_dn  = q0;
    nq1_dn  = q1;
    wrap_dn = 1'b0;
    if (q0 > 4'd9) begin
      nq0_dn = 4'd0;
    end else if (q0 > 4'd0) begin
      nq0_dn = q0 - 4'd1;
    end else begin
      nq0_dn = 4'd9;
      if (q1 == 4'd0) begin
        nq1_dn  = TMAX;
        wrap_dn = 1'b1;
      end else begin
        nq1_dn = q1 - 4'd1;
      end
    end
    if (q1 > TMAX) begin
      nq1_dn  = 4'd0;
      wrap_dn = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      q0   <= 4'd0;
      q1   <= 4'd0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      // The tick marks the prescaler period even when a load swallows the step.
      tick <= step_req;
      wrap <= 1'b0;
      if (enable) begin
        cnt <= step_req ? '0 : cnt + CNT_ONE;
      end
      if (any_load) begin
        if (load0) q0 <= ld0;
        if (load1) q1 <= ld1;
      end else if (step_req) begin
        if (up) begin
          q0   <= nq0_up;
          q1   <= nq1_up;
          wrap <= wrap_up;
        end else begin
          q0   <= nq0_dn;
          q1   <= nq1_dn;
          wrap <= wrap_dn;
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb/tb_stopwatch_counter.sv - directed self-checking bench for stopwatch_counter
module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       up;
  logic       load0;
  logic [3:0] load0_value;
  logic       load1;
  logic [3:0] load1_value;
  logic [3:0] q0;
  logic [3:0] q1;
  logic       tick;
  logic       wrap;

  int tests = 0;
  int fails = 0;

  stopwatch_counter #(.TICK_DIV(4), .TENS_MAX(5)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .up(up),
    .load0(load0),
    .load0_value(load0_value),
    .load1(load1),
    .load1_value(load1_value),
    .q0(q0),
    .q1(q1),
    .tick(tick),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic set_loads(input logic l0, input logic [3:0] v0,
                           input logic l1, input logic [3:0] v1);
    load0 = l0; load0_value = v0;
    load1 = l1; load1_value = v1;
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    up = 1'b1;
    set_loads(1'b0, 4'd0, 1'b0, 4'd0);

    // Reset state, held with enable high.
    cyc(2);
    chk8("reset_q", {q1, q0}, 8'h00);
    chk1("reset_tick", tick, 1'b0);
    chk1("reset_wrap", wrap, 1'b0);

    // Free run up for 40 cycles: tick on every 4th edge, first on the 4th.
    reset = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      cyc(1);
      chk1("run_tick", tick, (k % 4) == 0);
      chk1("run_wrap", wrap, 1'b0);
      if (k == 4) chk8("run_first_step", {q1, q0}, 8'h01);
    end
    chk8("run_40", {q1, q0}, 8'h10);

    // Load 58 while stopped, then count through 59 to 00 with wrap.
    enable = 1'b0;
    set_loads(1'b1, 4'd8, 1'b1, 4'd5);
    cyc(1);
    set_loads(1'b0, 4'd0, 1'b0, 4'd0);
    chk8("load58_q", {q1, q0}, 8'h58);
    chk1("load58_tick", tick, 1'b0);
    enable = 1'b1;
    cyc(3);
    chk1("pre59_tick", tick, 1'b0);
    chk8("pre59_q", {q1, q0}, 8'h58);
    cyc(1);
    chk8("up59_q", {q1, q0}, 8'h59);
    chk1("up59_tick", tick, 1'b1);
    chk1("up59_wrap", wrap, 1'b0);
    cyc(4);
    chk8("up00_q", {q1, q0}, 8'h00);
    chk1("up00_tick", tick, 1'b1);
    chk1("up00_wrap", wrap, 1'b1);

    // Load 00 and count down: underflow to 59 with wrap, then 58.
    enable = 1'b0;
    up = 1'b0;
    set_loads(1'b1, 4'd0, 1'b1, 4'd0);
    cyc(1);
    set_loads(1'b0, 4'd0, 1'b0, 4'd0);
    chk1("wrap_pulse_end", wrap, 1'b0);
    chk1("tick_pulse_end", tick, 1'b0);
    chk8("load00_q", {q1, q0}, 8'h00);
    enable = 1'b1;
    cyc(4);
    chk8("dn59_q", {q1, q0}, 8'h59);
    chk1("dn59_tick", tick, 1'b1);
    chk1("dn59_wrap", wrap, 1'b1);
    cyc(4);
    chk8("dn58_q", {q1, q0}, 8'h58);
    chk1("dn58_tick", tick, 1'b1);
    chk1("dn58_wrap", wrap, 1'b0);

    // Out-of-range load values clamp.
    enable = 1'b0;
    set_loads(1'b1, 4'd12, 1'b1, 4'd7);
    cyc(1);
    set_loads(1'b0, 4'd0, 1'b0, 4'd0);
    chk8("clamp_q", {q1, q0}, 8'h59);

    // Load on the step edge: loaded value kept, no increment or wrap, tick pulses.
    up = 1'b1;
    enable = 1'b1;
    cyc(3);
    chk1("preload_tick", tick, 1'b0);
    chk8("preload_q", {q1, q0}, 8'h59);
    set_loads(1'b1, 4'd3, 1'b1, 4'd2);
    cyc(1);
    set_loads(1'b0, 4'd0, 1'b0, 4'd0);
    chk8("loadstep_q", {q1, q0}, 8'h23);
    chk1("loadstep_tick", tick, 1'b1);
    chk1("loadstep_wrap", wrap, 1'b0);

    // Pause at cnt=2 for 10 cycles, then resume: step after 2 more cycles.
    cyc(2);
    chk1("mid_tick", tick, 1'b0);
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      chk1("pause_tick", tick, 1'b0);
      chk8("pause_q", {q1, q0}, 8'h23);
    end
    enable = 1'b1;
    cyc(1);
    chk1("resume1_tick", tick, 1'b0);
    chk8("resume1_q", {q1, q0}, 8'h23);
    cyc(1);
    chk8("resume2_q", {q1, q0}, 8'h24);
    chk1("resume2_tick", tick, 1'b1);

    // Reset on the step edge at 37 wins; prescaler restarts from 0.
    enable = 1'b0;
    set_loads(1'b1, 4'd7, 1'b1, 4'd3);
    cyc(1);
    set_loads(1'b0, 4'd0, 1'b0, 4'd0);
    chk8("load37_q", {q1, q0}, 8'h37);
    enable = 1'b1;
    cyc(3);
    chk8("pre_rst_q", {q1, q0}, 8'h37);
    chk1("pre_rst_tick", tick, 1'b0);
    reset = 1'b1;
    cyc(1);
    chk8("rst_step_q", {q1, q0}, 8'h00);
    chk1("rst_step_tick", tick, 1'b0);
    chk1("rst_step_wrap", wrap, 1'b0);
    reset = 1'b0;
    cyc(3);
    chk1("post_rst3_tick", tick, 1'b0);
    chk8("post_rst3_q", {q1, q0}, 8'h00);
    cyc(1);
    chk8("post_rst4_q", {q1, q0}, 8'h01);
    chk1("post_rst4_tick", tick, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
